// File: rtl/seq_bidir_shifter.sv
// seq_bidir_shifter: multi-cycle SRL / SLA / ROL shifter behind a valid/ready
// handshake, companion to the ALU's single-cycle combinational shifter.
// Produces a registered result plus Z/V/N flags at FLAG_Z/FLAG_V/FLAG_N.
// Optional feature macro: SEQ_SHIFT_FAST_EN (3-bit steps while cnt >= 3).

`ifndef FLAG_N
`define FLAG_N 0
`endif
`ifndef FLAG_V
`define FLAG_V 1
`endif
`ifndef FLAG_Z
`define FLAG_Z 2
`endif

module seq_bidir_shifter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] shift_in,
  input  logic [3:0]       shift_val,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] shift_out,
  output logic [2:0]       flag
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLA = 2'b01;
  localparam logic [1:0] MODE_ROL = 2'b10;

  state_t           state;
  logic [WIDTH-1:0] data;
  logic [3:0]       cnt;
  logic [1:0]       mode_q;
  logic             v_sticky;

  logic [WIDTH-1:0] step_data;
  logic [3:0]       step_size;
  logic             step_v;
  logic [2:0]       flag_next;

  // The block can only take a new request while idle.
  assign in_ready = (state == IDLE);

  // Next value of the working register for one shift step, plus the overflow
  // contribution of that step (sign change seen before the step for SLA).
  always_comb begin
    step_data = data;
    step_size = 4'd1;
    step_v    = 1'b0;
`ifdef SEQ_SHIFT_FAST_EN
    if (cnt >= 4'd3) begin
      step_size = 4'd3;
      case (mode_q)
        MODE_SRL: step_data = {3'b000, data[WIDTH-1:3]};
        MODE_SLA: begin
          step_data = {data[WIDTH-4:0], 3'b000};
          step_v    = !((data[WIDTH-1:WIDTH-4] == 4'b0000) ||
                        (data[WIDTH-1:WIDTH-4] == 4'b1111));
        end
        MODE_ROL: step_data = {data[WIDTH-4:0], data[WIDTH-1:WIDTH-3]};
        default:  step_data = data;
      endcase
    end else begin
`else
    begin
`endif
      case (mode_q)
        MODE_SRL: step_data = {1'b0, data[WIDTH-1:1]};
        MODE_SLA: begin
          step_data = {data[WIDTH-2:0], 1'b0};
          step_v    = data[WIDTH-1] ^ data[WIDTH-2];
        end
        MODE_ROL: step_data = {data[WIDTH-2:0], data[WIDTH-1]};
        default:  step_data = data;
      endcase
    end
  end

  // Flags derived from the finished working register; V only means overflow for SLA.
  always_comb begin
    flag_next          = 3'b000;
    flag_next[`FLAG_Z] = (data == '0);
    flag_next[`FLAG_N] = data[WIDTH-1];
    flag_next[`FLAG_V] = (mode_q == MODE_SLA) && v_sticky;
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      data      <= '0;
      cnt       <= 4'd0;
      mode_q    <= MODE_SRL;
      v_sticky  <= 1'b0;
      shift_out <= '0;
      flag      <= 3'b000;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mode_q   <= mode;
            v_sticky <= 1'b0;
            if (mode == 2'b11) begin
              // Reserved mode: result forced to zero with no steps taken.
              data <= '0;
              cnt  <= 4'd0;
            end else begin
              data <= shift_in;
              cnt  <= shift_val;
            end
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt != 4'd0) begin
            data     <= step_data;
            cnt      <= cnt - step_size;
            v_sticky <= v_sticky | step_v;
          end else begin
            shift_out <= data;
            flag      <= flag_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
